muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit; the consumer end of the ALU operand path.
//  Takes operand A (rs1) and operand B (rs2, from the rs2/imm select), runs a multi-cycle op, returns a result for writeback.
//  The core stalls while busy=1; done is a 1-cycle pulse that lets the stalled instruction retire.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  clk     in   1     rising-edge clock
//  rstn    in   1     asynchronous active-low reset
//  start   in   1     request; accepted only in IDLE
//  kill    in   1     abort current op (pipeline flush)
//  funct3  in   3     M-ext op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  A       in   XLEN  rs1 operand
//  B       in   XLEN  rs2 operand
//  busy    out  1     op in flight (CALC or DONE); stall request
//  done    out  1     1-cycle pulse; result valid on the same cycle
//  result  out  XLEN  registered result; held until the next accepted start
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE; busy=0, done=0, result=0; all internal registers cleared.
//  States: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: start=1 & kill=0 -> latch funct3, |A|, |B|, result-sign flags, cnt=0.
//     Special case -> DONE directly (latency 1):
//       DIV*/REM* with B=0: quotient=all ones, remainder=A.
//       DIV/REM with A=0x8000_0000 & B=0xFFFF_FFFF: quotient=0x8000_0000, remainder=0.
//     Otherwise -> CALC.
//   CALC: one radix-2 step per cycle; cnt increments.
//     MUL*: shift-add on a 2*XLEN accumulator.
//     DIV*/REM*: restoring shift-subtract (quotient + remainder registers).
//     At cnt=XLEN-1 -> DONE.
//   DONE: apply sign fixup, write result, done=1 for exactly this cycle, -> IDLE.
//  Latency, accepted start -> done: XLEN+1 cycles (33) normal; 1 cycle special case.
//  Next start can be accepted the cycle after done.
//  busy=1 in CALC and DONE; busy is combinational from state (no extra cycle).
//  Signedness:
//    MULH: both operands signed.  MULHSU: A signed, B unsigned.  MULHU/DIVU/REMU: unsigned.
//    Signed ops work on magnitudes; result negated in DONE when needed.
//    Quotient sign = sign(A)^sign(B); remainder sign = sign(A).
//  Result selection: MUL -> product[XLEN-1:0]; MULH/MULHSU/MULHU -> product[2*XLEN-1:XLEN];
//    DIV/DIVU -> quotient; REM/REMU -> remainder.
//  start while busy: ignored; the in-flight op is unaffected.
//  kill=1 in any state: -> IDLE next edge, no done pulse, result unchanged. Kill wins over start in IDLE.
//  A, B and funct3 are sampled only at acceptance; later changes have no effect.
//  rstn asserted mid-operation: immediate return to reset state; no done pulse.
// STRUCTURE
//  Shared package: funct3 op constants (MUL..REMU), state encoding (IDLE/CALC/DONE), XLEN default.
//  One natural sub-module: muldiv_step, a combinational single-iteration datapath (add-shift / subtract-shift) instanced in CALC.
//  Sign handling, the FSM and the result register stay in the top.
// TESTING
//  MUL A=7, B=-3 (0xFFFF_FFFD) -> done at cycle 33; result=0xFFFF_FFEB.
//  MULH A=0x8000_0000, B=0x8000_0000 -> result=0x4000_0000.
//  MULHU A=B=0xFFFF_FFFF -> 0xFFFF_FFFE.
//  MULHSU A=-1, B=0xFFFF_FFFF -> 0xFFFF_FFFF.
//  DIV A=-7, B=2 -> result=0xFFFF_FFFD (-3).
//  REM A=-7, B=2 -> result=0xFFFF_FFFF (-1).
//  DIVU A=100, B=7 -> 14.  REMU A=100, B=7 -> 2.
//  DIVU A=5, B=0 -> done after 1 cycle, result=0xFFFF_FFFF.  REM A=5, B=0 -> 5.
//  DIV A=0x8000_0000, B=-1 -> 1-cycle done, result=0x8000_0000.  REM, same operands -> 0.
//  Control: start during CALC is ignored (original result is returned).
//  Control: kill at cycle 10 -> busy drops next cycle, no done pulse, result keeps its old value.
//  Control: rstn pulsed low mid-CALC -> busy=0, done=0, result=0 immediately.
//  Control: back-to-back ops with start on the cycle after done -> both complete correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Holds the default datapath width, the funct3 encodings of the M-extension
// operations, the FSM state encoding and a small decode helper.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // M-extension funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Every divide/remainder op has funct3[2] set
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath, purely combinational.
// The same hi/lo register pair is reused by both operations:
//   multiply: {hi, lo} is the 2*XLEN shift-add accumulator, lo starts as the
//             multiplier, operand is the multiplicand.
//   divide:   hi is the partial remainder, lo shifts the dividend out and the
//             quotient in, operand is the divisor.
// Ports:
//   is_div   in   1     select restoring-divide step instead of shift-add
//   hi, lo   in   XLEN  current accumulator / remainder-quotient pair
//   operand  in   XLEN  multiplicand or divisor magnitude
//   hi_next  out  XLEN  updated high half / remainder
//   lo_next  out  XLEN  updated low half / quotient
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_shift;
    logic          div_fits;

    // The carry out of the add lands in the top accumulator bit as the pair
    // shifts right. For divide, the remainder stays below the divisor, so once
    // the subtraction fits its result needs only XLEN bits.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_fits  = (div_shift >= {1'b0, operand});
        if (is_div) begin
            hi_next = div_fits ? (div_shift[XLEN-1:0] - operand) : div_shift[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], div_fits};
        end else begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Signed operations are computed on
// operand magnitudes and the sign is restored when the result is written.
// Ports:
//   clk     in   1     rising-edge clock
//   rstn    in   1     asynchronous active-low reset
//   start   in   1     operation request, accepted only when idle
//   kill    in   1     abort the current operation (pipeline flush)
//   funct3  in   3     M-extension operation select
//   A, B    in   XLEN  rs1 / rs2 operands, sampled on acceptance
//   busy    out  1     operation in flight, stalls the core
//   done    out  1     one-cycle completion pulse, result valid alongside
//   result  out  XLEN  registered result, held until overwritten
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CW        = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state;
    logic [2:0]      op;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] operand;
    logic [CW-1:0]   cnt;
    logic            neg_main;
    logic            neg_rem;

    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_result;

    logic            step_is_div;
    logic [XLEN-1:0] hi_next;
    logic [XLEN-1:0] lo_next;

    logic [2*XLEN-1:0] product_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_result;

    // Operand decode at acceptance: signedness, magnitudes and the two divide
    // corner cases that bypass iteration. Plain MUL is treated as unsigned
    // because the low product half does not depend on signedness.
    always_comb begin
        a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
        b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        a_neg    = a_signed && A[XLEN-1];
        b_neg    = b_signed && B[XLEN-1];
        abs_a    = a_neg ? (~A + 1'b1) : A;
        abs_b    = b_neg ? (~B + 1'b1) : B;
        div_zero = is_div_op(funct3) && (B == '0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (A == INT_MIN) && (B == '1);
        // funct3[1] separates remainder ops from quotient ops
        if (div_zero) begin
            special_result = funct3[1] ? A : '1;
        end else begin
            special_result = funct3[1] ? '0 : INT_MIN;
        end
    end

    assign step_is_div = is_div_op(op);

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .is_div  (step_is_div),
        .hi      (hi),
        .lo      (lo),
        .operand (operand),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    // Result assembled from the last iteration's outputs so it can be written
    // on the same edge that enters DONE, making it valid alongside done.
    always_comb begin
        product_fix  = neg_main ? (~{hi_next, lo_next} + 1'b1) : {hi_next, lo_next};
        quo_fix      = neg_main ? (~lo_next + 1'b1) : lo_next;
        rem_fix      = neg_rem  ? (~hi_next + 1'b1) : hi_next;
        final_result = '0;
        case (op)
            F3_MUL:                       final_result = product_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: final_result = product_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              final_result = quo_fix;
            F3_REM, F3_REMU:              final_result = rem_fix;
            default:                      final_result = '0;
        endcase
    end

    // Control FSM and datapath registers. Kill overrides everything, including
    // a simultaneous start, and leaves the previous result untouched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            op       <= '0;
            hi       <= '0;
            lo       <= '0;
            operand  <= '0;
            cnt      <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            result   <= '0;
        end else if (kill) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op       <= funct3;
                        cnt      <= '0;
                        hi       <= '0;
                        neg_main <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        if (is_div_op(funct3)) begin
                            lo      <= abs_a;
                            operand <= abs_b;
                        end else begin
                            lo      <= abs_b;
                            operand <= abs_a;
                        end
                        if (div_zero || div_ovf) begin
                            result <= special_result;
                            state  <= ST_DONE;
                        end else begin
                            state  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    hi  <= hi_next;
                    lo  <= lo_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        result <= final_result;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_CALC) || (state == ST_DONE);
    assign done = (state == ST_DONE) && !kill;

endmodule
